// File: rtl/piece_mover.sv
// piece_mover: spawns, moves, rotates and locks the falling piece against board collision queries
module piece_mover #(
    parameter int         GRAV_FRAMES = 30,
    parameter logic [3:0] SPAWN_X     = 4'd4,
    parameter logic [4:0] SPAWN_Y     = 5'd0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] Game_State,
    input  logic       Active_O,
    input  logic       Active_T,
    input  logic       Active_RL,
    input  logic       Active_RF,
    input  logic       Active_LL,
    input  logic       Active_LF,
    input  logic       Active_I,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       UP,
    input  logic       DOWN,
    output logic       Query,
    output logic [3:0] Cand_X,
    output logic [4:0] Cand_Y,
    output logic [1:0] Cand_Rot,
    input  logic       Query_Ack,
    input  logic       Collide,
    output logic [2:0] Piece_Type,
    output logic [3:0] Piece_X,
    output logic [4:0] Piece_Y,
    output logic [1:0] Piece_Rot,
    output logic       Piece_Live,
    output logic       En_New_Static,
    output logic       Top_Out
);
    typedef enum logic [2:0] {IDLE, SPAWN_CHK, LIVE, MOVE_CHK, LOCK} state_t;
    state_t     state_q, state_d;
    logic       play, fc_q, fc_rise, counting, tick, grav;
    logic [2:0] spawn_type;
    logic [5:0] cnt_q, cnt_d;
    logic       pend_q, pend_d, down_q, down_d, top_q, top_d;
    logic [2:0] ctype_q, ctype_d, type_q, type_d;
    logic [3:0] cx_q, cx_d, px_q, px_d;
    logic [4:0] cy_q, cy_d, py_q, py_d;
    logic [1:0] cr_q, cr_d, pr_q, pr_d;
    assign play       = Game_State == 3'b001;
    assign fc_rise    = frame_clk & ~fc_q;
    assign counting   = state_q == LIVE || state_q == MOVE_CHK;
    assign tick       = counting && fc_rise && cnt_q == 6'(GRAV_FRAMES - 1);
    assign grav       = pend_q | tick;
    assign spawn_type = Active_O ? 3'd1 : Active_T ? 3'd2 : Active_RL ? 3'd3 : Active_RF ? 3'd4 :
                        Active_LL ? 3'd5 : Active_LF ? 3'd6 : Active_I ? 3'd7 : 3'd0;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            fc_q    <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            down_q  <= 1'b0;
            top_q   <= 1'b0;
            ctype_q <= '0;
            type_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cr_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pr_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= frame_clk;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            down_q  <= down_d;
            top_q   <= top_d;
            ctype_q <= ctype_d;
            type_q  <= type_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cr_q    <= cr_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pr_q    <= pr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = !counting ? 6'd0 : tick ? 6'd0 : fc_rise ? cnt_q + 6'd1 : cnt_q;
        pend_d  = pend_q | (state_q == MOVE_CHK && tick);
        down_d  = down_q;
        top_d   = 1'b0;
        ctype_d = ctype_q;
        type_d  = type_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cr_d    = cr_q;
        px_d    = px_q;
        py_d    = py_q;
        pr_d    = pr_q;
        if (!play) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (spawn_type != 3'd0) begin
                    ctype_d = spawn_type;
                    cx_d    = SPAWN_X;
                    cy_d    = SPAWN_Y;
                    cr_d    = 2'd0;
                    state_d = SPAWN_CHK;
                end
                SPAWN_CHK: if (Query_Ack) begin
                    if (Collide) begin
                        top_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        type_d  = ctype_q;
                        px_d    = cx_q;
                        py_d    = cy_q;
                        pr_d    = cr_q;
                        state_d = LIVE;
                    end
                end
                LIVE: begin
                    cx_d = px_q;
                    cy_d = py_q;
                    cr_d = pr_q;
                    if (grav || DOWN) begin
                        pend_d  = 1'b0;
                        down_d  = 1'b1;
                        cy_d    = py_q + 5'd1;
                        state_d = py_q == 5'd31 ? LOCK : MOVE_CHK;
                    end else if (LEFT) begin
                        down_d  = 1'b0;
                        cx_d    = px_q - 4'd1;
                        state_d = px_q == 4'd0 ? LIVE : MOVE_CHK;
                    end else if (RIGHT) begin
                        down_d  = 1'b0;
                        cx_d    = px_q + 4'd1;
                        state_d = px_q == 4'd15 ? LIVE : MOVE_CHK;
                    end else if (UP) begin
                        down_d  = 1'b0;
                        cr_d    = pr_q + 2'd1;
                        state_d = MOVE_CHK;
                    end
                end
                MOVE_CHK: if (Query_Ack) begin
                    if (!Collide) begin
                        px_d    = cx_q;
                        py_d    = cy_q;
                        pr_d    = cr_q;
                        state_d = LIVE;
                    end else begin
                        state_d = down_q ? LOCK : LIVE;
                    end
                end
                LOCK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d != LIVE && state_d != MOVE_CHK) begin
            cnt_d  = 6'd0;
            pend_d = 1'b0;
        end
    end
    always_comb begin
        Query         = state_q == SPAWN_CHK || state_q == MOVE_CHK;
        Piece_Live    = state_q == LIVE || state_q == MOVE_CHK || state_q == LOCK;
        En_New_Static = state_q == LOCK && play;
    end
    assign Top_Out    = top_q;
    assign Cand_X     = cx_q;
    assign Cand_Y     = cy_q;
    assign Cand_Rot   = cr_q;
    assign Piece_Type = type_q;
    assign Piece_X    = px_q;
    assign Piece_Y    = py_q;
    assign Piece_Rot  = pr_q;
endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: directed scoreboard bench for piece_mover spawn, gravity, moves, lock, top-out and aborts
module tb_piece_mover;
    logic       Clk = 0, Reset = 1, frame_clk = 0;
    logic [2:0] Game_State = 3'b000;
    logic       Active_O = 0, Active_T = 0, Active_RL = 0, Active_RF = 0, Active_LL = 0, Active_LF = 0, Active_I = 0;
    logic       LEFT = 0, RIGHT = 0, UP = 0, DOWN = 0, Query_Ack = 0, Collide = 0;
    logic       Query, Piece_Live, En_New_Static, Top_Out;
    logic [3:0] Cand_X, Piece_X;
    logic [4:0] Cand_Y, Piece_Y;
    logic [1:0] Cand_Rot, Piece_Rot;
    logic [2:0] Piece_Type;
    logic [13:0] pc;
    logic [10:0] cd;
    typedef struct {string tag; logic [31:0] exp;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    int t = 0, x = 0, y = 0, r = 0;
    always #5 Clk = ~Clk;
    assign pc = {Piece_Type, Piece_X, Piece_Y, Piece_Rot};
    assign cd = {Cand_X, Cand_Y, Cand_Rot};
    piece_mover #(.GRAV_FRAMES(3)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .Active_O(Active_O), .Active_T(Active_T), .Active_RL(Active_RL), .Active_RF(Active_RF),
        .Active_LL(Active_LL), .Active_LF(Active_LF), .Active_I(Active_I),
        .LEFT(LEFT), .RIGHT(RIGHT), .UP(UP), .DOWN(DOWN),
        .Query(Query), .Cand_X(Cand_X), .Cand_Y(Cand_Y), .Cand_Rot(Cand_Rot),
        .Query_Ack(Query_Ack), .Collide(Collide),
        .Piece_Type(Piece_Type), .Piece_X(Piece_X), .Piece_Y(Piece_Y), .Piece_Rot(Piece_Rot),
        .Piece_Live(Piece_Live), .En_New_Static(En_New_Static), .Top_Out(Top_Out)
    );
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask
    task automatic want(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask
    task automatic got(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask
    function automatic logic [13:0] model_pc();
        return {t[2:0], x[3:0], y[4:0], r[1:0]};
    endfunction
    task automatic spawn(input logic [6:0] mask, input bit col, input int code);
        {Active_O, Active_T, Active_RL, Active_RF, Active_LL, Active_LF, Active_I} = mask;
        cyc();
        {Active_O, Active_T, Active_RL, Active_RF, Active_LL, Active_LF, Active_I} = '0;
        want("spawn_query", 1);
        want("spawn_cand", {4'd4, 5'd0, 2'd0});
        got(Query);
        got(cd);
        Query_Ack = 1;
        Collide = col;
        cyc();
        Query_Ack = 0;
        Collide = 0;
        if (!col) begin
            t = code; x = 4; y = 0; r = 0;
        end
        want("spawn_piece", model_pc());
        want("spawn_live", !col);
        want("spawn_top", col);
        want("spawn_static", 0);
        want("spawn_qdrop", 0);
        got(pc);
        got(Piece_Live);
        got(Top_Out);
        got(En_New_Static);
        got(Query);
    endtask
    task automatic mv(input int k, input bit col);
        int nx, ny, nr;
        logic [3:0] keys;
        nx = x; ny = y; nr = r;
        if (k == 0) ny = y + 1;
        if (k == 1) nx = x - 1;
        if (k == 2) nx = x + 1;
        if (k == 3) nr = (r + 1) % 4;
        keys = 4'b1000 >> k;
        {DOWN, LEFT, RIGHT, UP} = keys;
        cyc();
        {DOWN, LEFT, RIGHT, UP} = '0;
        want("mv_query", 1);
        want("mv_cand", {nx[3:0], ny[4:0], nr[1:0]});
        got(Query);
        got(cd);
        Query_Ack = 1;
        Collide = col;
        cyc();
        Query_Ack = 0;
        Collide = 0;
        if (!col) begin
            x = nx; y = ny; r = nr;
        end
        want("mv_piece", model_pc());
        want("mv_live", 1);
        want("mv_qdrop", 0);
        got(pc);
        got(Piece_Live);
        got(Query);
    endtask
    initial begin
        repeat (2) cyc();
        want("rst_query", 0); want("rst_live", 0); want("rst_static", 0);
        want("rst_top", 0); want("rst_piece", 0); want("rst_cand", 0);
        got(Query); got(Piece_Live); got(En_New_Static); got(Top_Out); got(pc); got(cd);
        Reset = 0;
        Game_State = 3'b001;
        cyc();
        spawn(7'b0100000, 0, 2);
        repeat (5) mv(0, 0);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 3; i++) begin
                frame_clk = 1;
                cyc();
                frame_clk = 0;
                want("grav_query", i == 2);
                got(Query);
                cyc();
            end
            want("grav_cand", {x[3:0], 5'(y + 1), r[1:0]});
            got(cd);
            Query_Ack = 1;
            cyc();
            Query_Ack = 0;
            y = y + 1;
            want("grav_piece", model_pc());
            want("grav_qdrop", 0);
            got(pc);
            got(Query);
        end
        Active_I = 1;
        cyc();
        Active_I = 0;
        want("late_spawn_query", 0); want("late_spawn_piece", model_pc());
        got(Query); got(pc);
        repeat (11) mv(0, 0);
        DOWN = 1;
        cyc();
        DOWN = 0;
        want("lock_query", 1); want("lock_cand", {x[3:0], 5'd19, r[1:0]});
        got(Query); got(cd);
        Query_Ack = 1; Collide = 1; LEFT = 1;
        cyc();
        Query_Ack = 0; Collide = 0; LEFT = 0;
        want("lock_static", 1); want("lock_piece", {3'd2, x[3:0], 5'd18, r[1:0]});
        want("lock_live", 1); want("lock_query_off", 0);
        got(En_New_Static); got(pc); got(Piece_Live); got(Query);
        cyc();
        want("lock_static_end", 0); want("lock_live_end", 0); want("lock_idle_query", 0);
        got(En_New_Static); got(Piece_Live); got(Query);
        spawn(7'b1000001, 0, 1);
        repeat (4) mv(1, 0);
        LEFT = 1; RIGHT = 1; UP = 1;
        cyc();
        LEFT = 0; RIGHT = 0; UP = 0;
        want("edge_left_query", 0); want("edge_left_piece", model_pc());
        got(Query); got(pc);
        cyc();
        want("edge_discard_query", 0);
        got(Query);
        repeat (3) mv(3, 0);
        mv(3, 1);
        mv(3, 0);
        mv(2, 1);
        DOWN = 1;
        cyc();
        DOWN = 0;
        want("abort_query", 1);
        got(Query);
        Game_State = 3'b000;
        cyc();
        want("abort_query_off", 0); want("abort_live", 0); want("abort_static", 0);
        got(Query); got(Piece_Live); got(En_New_Static);
        Game_State = 3'b001;
        Query_Ack = 1;
        cyc();
        Query_Ack = 0;
        want("abort_no_commit", model_pc()); want("abort_live2", 0); want("abort_top", 0);
        got(pc); got(Piece_Live); got(Top_Out);
        spawn(7'b0010000, 1, 3);
        cyc();
        want("topout_end", 0); want("topout_live", 0);
        got(Top_Out); got(Piece_Live);
        spawn(7'b0000010, 0, 6);
        mv(1, 0);
        DOWN = 1;
        cyc();
        DOWN = 0;
        want("rst_abort_query", 1);
        got(Query);
        Reset = 1;
        cyc();
        Reset = 0;
        t = 0; x = 0; y = 0; r = 0;
        want("rst_abort_query_off", 0); want("rst_abort_live", 0); want("rst_abort_piece", 0);
        got(Query); got(Piece_Live); got(pc);
        Query_Ack = 1;
        cyc();
        Query_Ack = 0;
        want("rst_late_ack_piece", 0); want("rst_late_ack_live", 0);
        got(pc); got(Piece_Live);
        spawn(7'b0001000, 0, 4);
        repeat (11) mv(2, 0);
        RIGHT = 1;
        cyc();
        RIGHT = 0;
        want("edge_right_query", 0); want("edge_right_piece", model_pc());
        got(Query); got(pc);
        repeat (31) mv(0, 0);
        DOWN = 1;
        cyc();
        DOWN = 0;
        want("floor_static", 1); want("floor_query", 0); want("floor_piece", model_pc());
        got(En_New_Static); got(Query); got(pc);
        cyc();
        want("floor_live_end", 0);
        got(Piece_Live);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter GRAV_FRAMES, default 30, frame_clk rising edges per gravity step (range 1..63).
REQ-002 SHALL have parameter SPAWN_X, default 4'd4, spawn anchor column; parameter SPAWN_Y, default 5'd0, spawn anchor row.
REQ-003 SHALL have ports, in this order:
 - Clk  in  1  single system clock, all logic on posedge.
 - Reset  in  1  synchronous, active-high reset.
 - frame_clk  in  1  frame-rate level signal; rising edge = frame tick.
 - Game_State  in  3  3'b001 = play; other values = not playing.
 - Active_O, Active_T, Active_RL, Active_RF, Active_LL, Active_LF, Active_I  in  1 each  one-cycle spawn pulses (type codes 1..7 in that order).
 - LEFT, RIGHT, UP, DOWN  in  1 each  one-cycle key pulses; UP = rotate.
 - Query  out  1  collision query request, held until acknowledged.
 - Cand_X  out 4, Cand_Y  out 5, Cand_Rot  out 2  candidate placement under query.
 - Query_Ack  in  1  board acknowledges; Collide valid in same cycle.
 - Collide  in  1  1 = candidate overlaps stack or leaves field.
 - Piece_Type  out 3, Piece_X  out 4, Piece_Y  out 5, Piece_Rot  out 2  committed live piece.
 - Piece_Live  out  1  a piece is falling.
 - En_New_Static  out  1  one-cycle pulse: lock current piece into stack.
 - Top_Out  out  1  one-cycle pulse: spawn placement collided.

Function
REQ-004 SHALL implement states IDLE, SPAWN_CHK, LIVE, MOVE_CHK, LOCK.
REQ-005 IDLE: on any Active_* pulse with Game_State==3'b001, SHALL latch type code, set Cand=(SPAWN_X,SPAWN_Y,0), assert Query, go SPAWN_CHK next cycle; multiple Active_* high together -> lowest type code wins.
REQ-006 SPAWN_CHK: on Query_Ack with Collide=0 SHALL commit candidate, set Piece_Live=1, go LIVE; with Collide=1 SHALL pulse Top_Out one cycle, go IDLE, Piece_Live stays 0.
REQ-007 Query SHALL be asserted only in SPAWN_CHK/MOVE_CHK, stay high with Cand_* stable until the Query_Ack cycle, and drop the cycle after.
REQ-008 Gravity counter (6 bit) SHALL count frame_clk rising edges (posedge-Clk detected via one delay register) only in LIVE/MOVE_CHK; at count GRAV_FRAMES-1 plus edge it SHALL wrap to 0 and raise a gravity tick.
REQ-009 Gravity tick arriving in MOVE_CHK SHALL set a one-deep pending flag; further ticks while pending set are dropped.
REQ-010 LIVE: one request per cycle, priority pending/gravity tick > DOWN > LEFT > RIGHT > UP; lower-priority same-cycle key pulses SHALL be discarded.
REQ-011 Candidate: gravity/DOWN Y+1; LEFT X-1; RIGHT X+1; UP Rot+1 mod 4 (3 wraps to 0); other fields copy committed values.
REQ-012 LEFT at Piece_X==0 SHALL be ignored locally (no query); RIGHT at Piece_X==15 likewise; DOWN/gravity at Piece_Y==31 SHALL go directly to LOCK.
REQ-013 MOVE_CHK: Collide=0 -> commit candidate, LIVE; Collide=1 on downward request -> LOCK; Collide=1 on LEFT/RIGHT/UP -> keep committed values, LIVE.
REQ-014 Key pulses arriving in SPAWN_CHK/MOVE_CHK/LOCK SHALL be discarded.
REQ-015 LOCK: SHALL pulse En_New_Static exactly one cycle with Piece_* still holding the locked placement, then go IDLE with Piece_Live=0, counter and pending cleared.
REQ-016 Game_State leaving 3'b001 in any state SHALL force IDLE next cycle: Piece_Live=0, Query=0, counter/pending cleared, no En_New_Static or Top_Out pulse.
REQ-017 Spawn pulses outside IDLE SHALL be ignored.
REQ-018 Committed Piece_* SHALL change only on commit (REQ-006/013) or reset.

Reset
REQ-019 Reset SHALL force IDLE; all outputs 0; gravity counter, pending flag, frame_clk delay register 0; takes priority over all other inputs incl. mid-query (Query drops next cycle, late Query_Ack ignored).

Verification
REQ-020 Spawn: Game_State=001, Active_T pulse, Ack with Collide=0 in 2 cycles -> Piece_Type=2, X=4, Y=0, Rot=0, Piece_Live=1.
REQ-021 Gravity: GRAV_FRAMES=3, live at Y=5, 3 frame_clk edges, Collide=0 -> one query Cand_Y=6, Piece_Y=6; counter back to 0.
REQ-022 Lock: live at Y=18, DOWN pulse, Collide=1 -> En_New_Static high exactly 1 cycle with Piece_Y=18, then Piece_Live=0, IDLE.
REQ-023 Priority/boundary: LEFT+RIGHT+UP same cycle at X=0 -> LEFT chosen, ignored locally, no Query, X stays 0; UP at Rot=3 with Collide=0 -> Rot=0.
REQ-024 Top-out: spawn with Collide=1 -> Top_Out 1-cycle pulse, Piece_Live=0, no En_New_Static.
REQ-025 Abort: Reset (or Game_State=000) during MOVE_CHK before Ack -> next cycle Query=0, Piece_Live=0, later Ack causes no commit.
